// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART transmit arbiter
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    SEND   = 2'd2
  } uart_arb_state_t;

  localparam int UART_NUM_REQ_DEF     = 4;
  localparam int UART_TIMEOUT_CYC_DEF = 1024;
  localparam int UART_BYTE_W          = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, search starts just after last_grant
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_grant,
  output logic [N-1:0]    grant_oh,
  output logic [ID_W-1:0] grant_idx
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = ID_W'((int'(last_grant) + k) % N);
      if (!found && req[idx]) begin
        found         = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locked sharing of the UART transmit byte port
// Optional ACCEPT-stall timeout enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = UART_NUM_REQ_DEF,
  parameter int ID_W        = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYC = UART_TIMEOUT_CYC_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tx_enable,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [UART_BYTE_W-1:0]         data_tx,
  output logic                           data_tx_wr,
  input  logic                           data_tx_ack,
  output logic [ID_W-1:0]                grant_id,
  output logic                           busy
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  output logic                           timeout_err
`endif
);

  if (NUM_REQ < 2 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: NUM_REQ and TIMEOUT_CYC must both be at least 2");
  end

  uart_arb_state_t state, state_d;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic               buf_last;
  logic               do_grant;
  logic               do_accept;
  logic               do_release;

  rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant_oh   (pick_oh),
    .grant_idx  (pick_idx)
  );

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tout_cnt;
  logic             tout_hit;
  logic             do_timeout;

  // Hit on the TIMEOUT_CYC-th consecutive ACCEPT cycle without a handshake.
  assign tout_hit = (state == ACCEPT) && (tout_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tout_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= do_timeout;
      if (state != ACCEPT || do_accept || do_timeout) tout_cnt <= '0;
      else                                            tout_cnt <= tout_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    do_grant   = 1'b0;
    do_accept  = 1'b0;
    do_release = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    do_timeout = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (tx_enable && |pick_oh) begin
          do_grant = 1'b1;
          state_d  = ACCEPT;
        end
      end
      ACCEPT: begin
        if (req_valid[grant_id]) begin
          do_accept = 1'b1;
          state_d   = SEND;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (tout_hit) begin
          do_timeout = 1'b1;
          do_release = 1'b1;
          state_d    = IDLE;
        end
`endif
      end
      SEND: begin
        if (data_tx_ack) begin
          do_release = buf_last;
          state_d    = buf_last ? IDLE : ACCEPT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready depends only on state and owner so requesters never see a valid->ready loop.
  always_comb begin
    req_ready = '0;
    if (state == ACCEPT) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id   <= '0;
      busy       <= 1'b0;
      last_grant <= ID_W'(NUM_REQ - 1);
      data_tx    <= '0;
      data_tx_wr <= 1'b0;
      buf_last   <= 1'b0;
    end else begin
      if (do_grant) begin
        grant_id <= pick_idx;
        busy     <= 1'b1;
      end
      if (do_accept) begin
        data_tx    <= UART_BYTE_W'(req_data >> (int'(grant_id) * UART_BYTE_W));
        buf_last   <= req_last[grant_id];
        data_tx_wr <= 1'b1;
      end
      if (state == SEND && data_tx_ack) data_tx_wr <= 1'b0;
      if (do_release) begin
        last_grant <= grant_id;
        busy       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int STALL = 10;
`else
  localparam int STALL = 20;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_enable = 1'b1;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  data_tx;
  logic        data_tx_wr;
  logic        data_tx_ack = 1'b0;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  int         total[4] = '{0, 0, 0, 0};
  int         plen[4]  = '{1, 1, 1, 1};
  logic [7:0] base[4]  = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [3:0] stall    = 4'b0000;
  int         sent[4];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [7:0] t2_b[8]  = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h12, 8'h13};
  int         t2_id[8] = '{0, 0, 1, 1, 3, 3, 0, 0};

  uart_tx_arbiter #(
    .NUM_REQ     (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_enable   (tx_enable),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .data_tx     (data_tx),
    .data_tx_wr  (data_tx_wr),
    .data_tx_ack (data_tx_ack),
    .grant_id    (grant_id),
    .busy        (busy)
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  initial forever #5 clk = ~clk;

  // Requester model: each requester streams total[i] bytes base[i]+n in packets of plen[i].
  always_comb begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = (sent[i] < total[i]) && !stall[i];
      req_data[8*i +: 8] = base[i] + 8'(sent[i]);
      req_last[i]        = (sent[i] % plen[i]) == plen[i] - 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) sent[i] <= 0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (req_valid[i] && req_ready[i]) sent[i] <= sent[i] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_byte(input string tag, input logic [7:0] exp_b, input int exp_id);
    int n = 0;
    while (!data_tx_wr && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_wr"}, 32'(data_tx_wr), 32'd1);
    chk({tag, "_data"}, 32'(data_tx), 32'(exp_b));
    chk({tag, "_gid"}, 32'(grant_id), 32'(exp_id));
    tick(2);
    data_tx_ack = 1'b1;
    tick(1);
    data_tx_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("rst_wr", 32'(data_tx_wr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_data", 32'(data_tx), 0);

    // single 2-byte packet from requester 2
    total[2] = 2; plen[2] = 2; base[2] = 8'h41;
    tick(1);
    chk("t1_gid", 32'(grant_id), 2);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_ready", 32'(req_ready), 32'h4);
    chk("t1_wr_pre", 32'(data_tx_wr), 0);
    tick(1);
    chk("t1_wr_rise", 32'(data_tx_wr), 1);
    chk("t1_ready_send", 32'(req_ready), 0);
    ack_byte("t1b0", 8'h41, 2);
    chk("t1_wr_drop", 32'(data_tx_wr), 0);
    chk("t1_ready2", 32'(req_ready), 32'h4);
    ack_byte("t1b1", 8'h42, 2);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_wr_end", 32'(data_tx_wr), 0);
    chk("t1_gid_end", 32'(grant_id), 2);

    // contention between requesters 0, 1, 3
    rst = 1'b1;
    total = '{4, 2, 0, 2};
    plen  = '{2, 2, 1, 2};
    base  = '{8'h10, 8'h20, 8'h00, 8'h30};
    tick(1);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) ack_byte($sformatf("t2_%0d", k), t2_b[k], t2_id[k]);
    chk("t2_busy_end", 32'(busy), 0);

    // owner 1 stalls mid-packet while requester 2 waits
    rst = 1'b1;
    total = '{0, 3, 1, 0};
    plen  = '{1, 3, 1, 1};
    base  = '{8'h00, 8'h50, 8'h60, 8'h00};
    tick(1);
    rst = 1'b0;
    ack_byte("t3b0", 8'h50, 1);
    stall[1] = 1'b1;
    for (int k = 0; k < STALL; k++) begin
      if (k == 5) data_tx_ack = 1'b1;
      tick(1);
      data_tx_ack = 1'b0;
      chk($sformatf("t3_lock_%0d", k), 32'(req_ready), 32'h2);
    end
    chk("t3_stray_ack_wr", 32'(data_tx_wr), 0);
    chk("t3_busy", 32'(busy), 1);
    stall[1] = 1'b0;
    ack_byte("t3b1", 8'h51, 1);
    ack_byte("t3b2", 8'h52, 1);
    ack_byte("t3b3", 8'h60, 2);

    // tx_enable dropped during byte 2 of a 3-byte packet
    rst = 1'b1;
    total = '{3, 1, 0, 0};
    plen  = '{3, 1, 1, 1};
    base  = '{8'h70, 8'h80, 8'h00, 8'h00};
    tick(1);
    rst = 1'b0;
    ack_byte("t4b0", 8'h70, 0);
    tick(1);
    tx_enable = 1'b0;
    ack_byte("t4b1", 8'h71, 0);
    ack_byte("t4b2", 8'h72, 0);
    tick(5);
    chk("t4_dis_busy", 32'(busy), 0);
    chk("t4_dis_ready", 32'(req_ready), 0);
    chk("t4_dis_gid", 32'(grant_id), 0);
    tx_enable = 1'b1;
    tick(1);
    chk("t4_regrant_gid", 32'(grant_id), 1);
    chk("t4_regrant_busy", 32'(busy), 1);
    ack_byte("t4b3", 8'h80, 1);

    // asynchronous reset while a byte is in flight
    total[0] = 4;
    total[3] = 2; plen[3] = 2; base[3] = 8'h90;
    tick(2);
    chk("t5_wr_before", 32'(data_tx_wr), 1);
    chk("t5_gid_before", 32'(grant_id), 3);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_wr", 32'(data_tx_wr), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_ready", 32'(req_ready), 0);
    chk("t5_rst_data", 32'(data_tx), 0);
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("t5_prio_gid", 32'(grant_id), 0);
    chk("t5_prio_busy", 32'(busy), 1);

`ifdef UART_TX_ARB_TIMEOUT_EN
    stall[0] = 1'b1;
    tick(15);
    chk("t6_no_tout", 32'(timeout_err), 0);
    chk("t6_busy_hold", 32'(busy), 1);
    tick(1);
    chk("t6_tout", 32'(timeout_err), 1);
    chk("t6_busy_drop", 32'(busy), 0);
    tick(1);
    chk("t6_tout_pulse", 32'(timeout_err), 0);
    chk("t6_next_gid", 32'(grant_id), 3);
    chk("t6_next_busy", 32'(busy), 1);
`endif

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
